// File: rtl/hbridge_multi_ctrl.sv
// Multi-channel H-bridge controller: request synchronisation, dead time,
// coil-energy tracking, flyback discharge and max on-time protection.
module hbridge_multi_ctrl #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEAD_CYC    = 2,
  parameter int unsigned MAX_ON      = 50000,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   req_f,
  input  logic [NCH-1:0]   req_r,
  output logic [NCH-1:0]   q1,
  output logic [NCH-1:0]   q2,
  output logic [NCH-1:0]   q3,
  output logic [NCH-1:0]   q4,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   blocked,
  output logic [NCH-1:0]   ovr,
  output logic [NCH-1:0]   illegal,
  input  logic [SEL_W-1:0] esel,
  output logic [CNT_W-1:0] energy
);

  localparam int unsigned      DW    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] MAXV  = CNT_W'(MAX_ON);
  localparam logic [DW-1:0]    DEADV = DW'(DEAD_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_F, S_PRE_R, S_DRV_F, S_DRV_R, S_FLY
  } state_t;

  logic [NCH-1:0][CNT_W-1:0] ecnt;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sf, sr;
    logic rf, rr, f_eff, r_eff, want_same, want_opp;
    state_t st, nxt;
    logic dir_q, dir_d, ovr_q, ovr_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] e_q, e_d, e_inc;
    logic q1_q, q2_q, q3_q, q4_q, busy_q, blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sf <= '0;
        sr <= '0;
      end else begin
        sf <= {sf[SYNC_STAGES-2:0], req_f[g]};
        sr <= {sr[SYNC_STAGES-2:0], req_r[g]};
      end
    end

    assign rf        = sf[SYNC_STAGES-1];
    assign rr        = sr[SYNC_STAGES-1];
    assign f_eff     = rf & ~rr & en;
    assign r_eff     = rr & ~rf & en;
    assign want_same = dir_q ? r_eff : f_eff;
    assign want_opp  = dir_q ? f_eff : r_eff;
    assign e_inc     = (e_q >= MAXV) ? MAXV : e_q + CNT_W'(1);

    // Energy counts every cycle whose next state is DRV, so the exit edge
    // needs no extra increment and FLY lasts exactly the stored count.
    always_comb begin
      nxt    = st;
      dir_d  = dir_q;
      dcnt_d = dcnt_q;
      e_d    = e_q;
      ovr_d  = ovr_q & (rf | rr);
      unique case (st)
        S_IDLE: begin
          e_d = '0;
          if (!ovr_q && (f_eff || r_eff)) begin
            dir_d = r_eff;
            if (DEAD_CYC == 0) begin
              nxt = r_eff ? S_DRV_R : S_DRV_F;
              e_d = CNT_W'(1);
            end else begin
              nxt    = r_eff ? S_PRE_R : S_PRE_F;
              dcnt_d = DEADV;
            end
          end
        end
        S_PRE_F, S_PRE_R: begin
          if (!want_same) begin
            nxt = (e_q == '0) ? S_IDLE : S_FLY;
          end else if (dcnt_q <= DW'(1)) begin
            nxt = dir_q ? S_DRV_R : S_DRV_F;
            e_d = e_inc;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        S_DRV_F, S_DRV_R: begin
          if (e_q >= MAXV) begin
            nxt   = S_FLY;
            ovr_d = 1'b1;
          end else if (!want_same) begin
            nxt = S_FLY;
          end else begin
            e_d = e_inc;
          end
        end
        S_FLY: begin
          if (want_same && !ovr_q) begin
            if (DEAD_CYC == 0) begin
              nxt = dir_q ? S_DRV_R : S_DRV_F;
              e_d = e_inc;
            end else begin
              nxt    = dir_q ? S_PRE_R : S_PRE_F;
              dcnt_d = DEADV;
            end
          end else if (e_q <= CNT_W'(1)) begin
            nxt = S_IDLE;
            e_d = '0;
          end else begin
            e_d = e_q - CNT_W'(1);
          end
        end
        default: nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= S_IDLE;
        dir_q  <= 1'b0;
        ovr_q  <= 1'b0;
        dcnt_q <= '0;
        e_q    <= '0;
        q1_q   <= 1'b1;
        q2_q   <= 1'b0;
        q3_q   <= 1'b1;
        q4_q   <= 1'b0;
        busy_q <= 1'b0;
        blk_q  <= 1'b0;
      end else begin
        st     <= nxt;
        dir_q  <= dir_d;
        ovr_q  <= ovr_d;
        dcnt_q <= dcnt_d;
        e_q    <= e_d;
        q1_q   <= nxt inside {S_IDLE, S_PRE_F, S_DRV_F, S_FLY};
        q3_q   <= nxt inside {S_IDLE, S_PRE_R, S_DRV_R, S_FLY};
        q2_q   <= (nxt == S_DRV_R);
        q4_q   <= (nxt == S_DRV_F);
        busy_q <= (nxt != S_IDLE);
        blk_q  <= (nxt == S_FLY) && want_opp;
      end
    end

    assign q1[g]      = q1_q;
    assign q2[g]      = q2_q;
    assign q3[g]      = q3_q;
    assign q4[g]      = q4_q;
    assign busy[g]    = busy_q;
    assign blocked[g] = blk_q;
    assign ovr[g]     = ovr_q;
    assign illegal[g] = rf & rr;
    assign ecnt[g]    = e_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) energy <= '0;
    else        energy <= (int'(esel) < int'(NCH)) ? ecnt[esel] : '0;
  end

endmodule

// File: tb/tb_hbridge_multi_ctrl.sv
// Bench for hbridge_multi_ctrl: directed scenarios plus randomized requests,
// compared each cycle against a behavioural channel model.
module tb_hbridge_multi_ctrl;
  localparam int NCH = 2, CNT_W = 16, DEAD = 2, MAXON = 200, SYNC = 2;
  localparam int M_IDLE = 0, M_PRE = 1, M_DRV = 2, M_FLY = 3;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [NCH-1:0] req_f = '0, req_r = '0;
  logic [0:0] esel = '0;
  logic [NCH-1:0] q1, q2, q3, q4, busy, blocked, ovr, illegal;
  logic [CNT_W-1:0] energy;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  hbridge_multi_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .DEAD_CYC(DEAD), .MAX_ON(MAXON), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_f(req_f), .req_r(req_r),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .busy(busy), .blocked(blocked),
    .ovr(ovr), .illegal(illegal), .esel(esel), .energy(energy)
  );

  // Behavioural model: request history, phase, direction, energy per channel
  int mode [NCH];
  bit mdir [NCH];
  int pre_n [NCH];
  int men [NCH];
  bit movr [NCH];
  bit mblk [NCH];
  bit hist_f [NCH][SYNC];
  bit hist_r [NCH][SYNC];

  // Directed-scenario statistics on channel 0
  int t, first_busy, first_q3lo, first_q4, first_q2;
  int n_q4, n_fly, n_blk, n_ill, n_busy, e_max;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_IDLE; mdir[c] = 0; pre_n[c] = 0; men[c] = 0;
      movr[c] = 0; mblk[c] = 0;
      for (int s = 0; s < SYNC; s++) begin
        hist_f[c][s] = 0; hist_r[c][s] = 0;
      end
    end
  endfunction

  function automatic void begin_drive(int c);
    if (DEAD == 0) begin
      mode[c] = M_DRV;
      men[c] = (men[c] >= MAXON) ? MAXON : men[c] + 1;
    end else begin
      mode[c] = M_PRE;
      pre_n[c] = 1;
    end
  endfunction

  function automatic void model_step(logic [NCH-1:0] f, logic [NCH-1:0] r, logic e);
    for (int c = 0; c < NCH; c++) begin
      bit rf, rr, fw, rw, same, opp, o;
      rf = hist_f[c][SYNC-1];
      rr = hist_r[c][SYNC-1];
      for (int s = SYNC - 1; s > 0; s--) begin
        hist_f[c][s] = hist_f[c][s-1];
        hist_r[c][s] = hist_r[c][s-1];
      end
      hist_f[c][0] = f[c];
      hist_r[c][0] = r[c];
      fw = rf && !rr && e;
      rw = rr && !rf && e;
      same = mdir[c] ? rw : fw;
      opp  = mdir[c] ? fw : rw;
      o = movr[c] && (rf || rr);
      case (mode[c])
        M_IDLE: begin
          men[c] = 0;
          if (!movr[c] && (fw || rw)) begin
            mdir[c] = rw;
            begin_drive(c);
          end
        end
        M_PRE: begin
          if (!same) mode[c] = (men[c] == 0) ? M_IDLE : M_FLY;
          else if (pre_n[c] >= DEAD) begin
            mode[c] = M_DRV;
            men[c] = (men[c] >= MAXON) ? MAXON : men[c] + 1;
          end else pre_n[c]++;
        end
        M_DRV: begin
          if (men[c] >= MAXON) begin
            mode[c] = M_FLY;
            o = 1;
          end else if (!same) mode[c] = M_FLY;
          else men[c]++;
        end
        default: begin
          if (same && !movr[c]) begin_drive(c);
          else if (men[c] <= 1) begin
            mode[c] = M_IDLE;
            men[c] = 0;
          end else men[c]--;
        end
      endcase
      mblk[c] = (mode[c] == M_FLY) && opp;
      movr[c] = o;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mark();
    t = 0; first_busy = 0; first_q3lo = 0; first_q4 = 0; first_q2 = 0;
    n_q4 = 0; n_fly = 0; n_blk = 0; n_ill = 0; n_busy = 0; e_max = 0;
  endtask

  task automatic tick();
    logic [NCH-1:0] e1, e2, e3, e4, eb, ebl, eo, ei;
    int ee;
    @(posedge clk);
    ee = rst_n ? men[esel] : 0;
    if (!rst_n) model_reset();
    else model_step(req_f, req_r, en);
    #1;
    for (int c = 0; c < NCH; c++) begin
      bit idle_like, drv;
      idle_like = (mode[c] == M_IDLE) || (mode[c] == M_FLY);
      drv = (mode[c] == M_DRV);
      e1[c] = idle_like || !mdir[c];
      e3[c] = idle_like || mdir[c];
      e4[c] = drv && !mdir[c];
      e2[c] = drv && mdir[c];
      eb[c] = (mode[c] != M_IDLE);
      ebl[c] = mblk[c];
      eo[c] = movr[c];
      ei[c] = hist_f[c][SYNC-1] && hist_r[c][SYNC-1];
    end
    chk("q1", 32'(q1), 32'(e1));
    chk("q2", 32'(q2), 32'(e2));
    chk("q3", 32'(q3), 32'(e3));
    chk("q4", 32'(q4), 32'(e4));
    chk("busy", 32'(busy), 32'(eb));
    chk("blocked", 32'(blocked), 32'(ebl));
    chk("ovr", 32'(ovr), 32'(eo));
    chk("illegal", 32'(illegal), 32'(ei));
    chk("energy", 32'(energy), 32'(ee));
    chk("shoot_through", 32'({q1 & q2, q3 & q4, q2 & q4}), 32'(0));
    t++;
    if (busy[0] && first_busy == 0) first_busy = t;
    if (!q3[0] && first_q3lo == 0) first_q3lo = t;
    if (q4[0] && first_q4 == 0) first_q4 = t;
    if (q2[0] && first_q2 == 0) first_q2 = t;
    if (q4[0]) n_q4++;
    if (busy[0] && q1[0] && q3[0]) n_fly++;
    if (blocked[0]) n_blk++;
    if (illegal[0]) n_ill++;
    if (busy[0]) n_busy++;
    if (int'(energy) > e_max) e_max = int'(energy);
  endtask

  task automatic drain();
    int n = 0;
    req_f = '0; req_r = '0; en = 1'b1;
    while (busy !== '0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'(0));
    repeat (3) tick();
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_q1", 32'(q1), 32'(2'b11));
    chk("arst_q3", 32'(q3), 32'(2'b11));
    chk("arst_q2q4", 32'({q2, q4}), 32'(0));
    chk("arst_flags", 32'({busy, blocked, ovr, illegal}), 32'(0));
    chk("arst_energy", 32'(energy), 32'(0));
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold [NCH];
    int enhold;
    model_reset();
    mark();

    // Reset with forward requests held, then release
    req_f = '1;
    repeat (3) tick();
    chk("rst_q1", 32'(q1), 32'(2'b11));
    chk("rst_q3", 32'(q3), 32'(2'b11));
    chk("rst_q2q4", 32'({q2, q4}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_energy", 32'(energy), 32'(0));
    #2 rst_n = 1'b1;
    mark();
    repeat (4) tick();
    chk("start_latency", 32'(first_busy), 32'(SYNC + 1));
    drain();

    // 10-cycle forward pulse on channel 0
    mark();
    req_f = 2'b01;
    repeat (10) tick();
    req_f = '0;
    repeat (25) tick();
    chk("pulse_q3_fall", 32'(first_q3lo), 32'(3));
    chk("pulse_q4_rise", 32'(first_q4), 32'(5));
    chk("pulse_q4_len", 32'(n_q4), 32'(8));
    chk("pulse_energy", 32'(e_max), 32'(8));
    chk("pulse_fly_len", 32'(n_fly), 32'(8));
    chk("pulse_ch1_idle", 32'({busy[1], q1[1], q3[1]}), 32'(3'b011));

    // Reversal: forward 20 cycles, reverse raised as forward drops
    mark();
    req_f = 2'b01;
    repeat (20) tick();
    req_f = '0;
    req_r = 2'b01;
    repeat (30) tick();
    chk("rev_blocked_len", 32'(n_blk), 32'(18));
    chk("rev_q2_rise", 32'(first_q2), 32'(44));
    drain();

    // Max on-time trip
    mark();
    req_f = 2'b01;
    repeat (450) tick();
    chk("trip_q4_len", 32'(n_q4), 32'(MAXON));
    chk("trip_fly_len", 32'(n_fly), 32'(MAXON));
    chk("trip_energy", 32'(e_max), 32'(MAXON));
    chk("trip_ovr", 32'(ovr[0]), 32'(1));
    chk("trip_no_redrive", 32'(busy[0]), 32'(0));
    req_f = '0;
    repeat (4) tick();
    chk("trip_ovr_clear", 32'(ovr[0]), 32'(0));
    mark();
    req_f = 2'b01;
    repeat (10) tick();
    req_f = '0;
    repeat (25) tick();
    chk("trip_next_pulse", 32'(n_q4), 32'(8));

    // Both requests together
    mark();
    req_f = 2'b01;
    req_r = 2'b01;
    repeat (5) tick();
    req_f = '0;
    req_r = '0;
    repeat (6) tick();
    chk("illegal_len", 32'(n_ill), 32'(5));
    chk("illegal_no_drive", 32'(n_busy), 32'(0));
    req_f = 2'b01;
    repeat (10) tick();
    req_r = 2'b01;
    repeat (6) tick();
    chk("illegal_in_drv", 32'({busy[0], q1[0], q3[0], q4[0]}), 32'(4'b1110));
    drain();

    // Enable drop at energy 40, then async reset mid-flyback
    req_f = 2'b01;
    repeat (44) tick();
    en = 1'b0;
    mark();
    repeat (50) tick();
    chk("en_fly_len", 32'(n_fly), 32'(40));
    chk("en_energy", 32'(e_max), 32'(40));
    chk("en_idle_hold", 32'(busy[0]), 32'(0));
    en = 1'b1;
    repeat (20) tick();
    req_f = '0;
    repeat (5) tick();
    async_reset_check();
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    enhold = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          int r;
          r = int'($urandom_range(0, 99));
          req_f[c] = 1'b0;
          req_r[c] = 1'b0;
          hold[c] = int'($urandom_range(1, 40));
          if (r < 35) begin
          end else if (r < 60) req_f[c] = 1'b1;
          else if (r < 85) req_r[c] = 1'b1;
          else if (r < 92) begin
            req_f[c] = 1'b1;
            req_r[c] = 1'b1;
          end else begin
            if (r[0]) req_f[c] = 1'b1;
            else req_r[c] = 1'b1;
            hold[c] = int'($urandom_range(220, 260));
          end
        end else hold[c]--;
      end
      if (enhold > 0) begin
        enhold--;
        if (enhold == 0) en = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        en = 1'b0;
        enhold = int'($urandom_range(1, 12));
      end
      esel = 1'($urandom_range(0, NCH - 1));
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
